dff_edge_sequencer: RTL and testbench

- Controller that sequences a single DUT flip-flop through a programmed list of capture steps.
- Per step it generates the DUT clock pulse and data, with the data applied either ahead of the posedge (setup mode) or in the same cycle as the posedge (simultaneous mode).
- After each posedge it samples the DUT output against the expected value and accumulates a pass/fail record.
- Sits between the timing-test harness and a flop under test, such as the dff_test family, so that same-timestamp capture regressions run as self-checking hardware instead of VCD inspection.

---
 rtl/dff_seq_pkg.sv | 19 +
 rtl/dff_seq_checker.sv | 70 +++++++
 rtl/dff_edge_sequencer.sv | 156 +++++++++++++++
 tb/tb_dff_edge_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dff_seq_pkg.sv
// Shared types and helpers for the DUT flip-flop edge sequencer.
package dff_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HIGH,
    LOW,
    DONE
  } state_e;

  localparam int STEP_CYCLES = 3;

  // Data driven in the cycle before the DUT posedge.
  function automatic logic pre_edge_data(input logic simul, input logic pre_d, input logic d);
    return simul ? pre_d : d;
  endfunction

endpackage

// File: rtl/dff_seq_checker.sv
// Latches the expected-q vector at run start and scores each step's sampled DUT output.
module dff_seq_checker
  import dff_seq_pkg::*;
#(
  parameter int NUM_STEPS = 5,
  parameter int CNT_W     = $clog2(NUM_STEPS + 1),
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [NUM_STEPS-1:0] expect_in,
  input  logic                 sample,
  input  logic                 last,
  input  logic [IDX_W-1:0]     idx,
  input  logic                 dut_q,
  output logic [CNT_W-1:0]     fail_count,
  output logic [NUM_STEPS-1:0] fail_mask,
  output logic                 pass
);

  logic [NUM_STEPS-1:0] exp_q, exp_d;
  logic [CNT_W-1:0]     fail_count_q, fail_count_d;
  logic [NUM_STEPS-1:0] fail_mask_q, fail_mask_d;
  logic                 pass_q, pass_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    exp_d        = exp_q;
    fail_count_d = fail_count_q;
    fail_mask_d  = fail_mask_q;
    pass_d       = pass_q;
    if (load) begin
      exp_d        = expect_in;
      fail_count_d = '0;
      fail_mask_d  = '0;
      pass_d       = 1'b0;
    end else if (sample) begin
      // Case inequality so an X or Z on dut_q scores as a mismatch.
      if (dut_q !== exp_q[idx]) begin
        fail_mask_d[idx] = 1'b1;
        if (fail_count_q != CNT_W'(NUM_STEPS)) fail_count_d = fail_count_q + 1'b1;
      end
      if (last) pass_d = (fail_count_d == '0);
    end
  end

  // NOTE: exp_q is a data register only read while a run is active, so it needs no reset.
  always_ff @(posedge clk) begin
    exp_q <= exp_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      fail_count_q <= '0;
      fail_mask_q  <= '0;
      pass_q       <= 1'b0;
    end else begin
      fail_count_q <= fail_count_d;
      fail_mask_q  <= fail_mask_d;
      pass_q       <= pass_d;
    end
  end

  assign fail_count = fail_count_q;
  assign fail_mask  = fail_mask_q;
  assign pass       = pass_q;

endmodule

// File: rtl/dff_edge_sequencer.sv
// Steps a single flop under test through PRE/HIGH/LOW capture cycles and scores each capture.
module dff_edge_sequencer
  import dff_seq_pkg::*;
#(
  parameter int NUM_STEPS = 5,
  parameter int CNT_W     = $clog2(NUM_STEPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_STEPS-1:0] step_d,
  input  logic [NUM_STEPS-1:0] step_pre_d,
  input  logic [NUM_STEPS-1:0] step_simul,
  input  logic [NUM_STEPS-1:0] step_expect,
  input  logic                 dut_q,
  output logic                 dut_clk,
  output logic                 dut_d,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     fail_count,
  output logic [NUM_STEPS-1:0] fail_mask
);

  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_STEPS-1:0] data_vec_q, data_vec_d;
  logic [NUM_STEPS-1:0] pre_vec_q, pre_vec_d;
  logic [NUM_STEPS-1:0] simul_vec_q, simul_vec_d;
  logic                 dut_clk_q, dut_clk_d;
  logic                 dut_d_q, dut_d_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load, sample, last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = PRE;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      PRE:  state_d = HIGH;
      HIGH: state_d = LOW;
      LOW: begin
        sample = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = PRE;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last = sample && (idx_q == LAST_IDX);

  // Step vectors are frozen at start; the output decode below reads the post-load copy.
  always_comb begin
    data_vec_d  = load ? step_d     : data_vec_q;
    pre_vec_d   = load ? step_pre_d : pre_vec_q;
    simul_vec_d = load ? step_simul : simul_vec_q;
  end

  always_ff @(posedge clk) begin
    data_vec_q  <= data_vec_d;
    pre_vec_q   <= pre_vec_d;
    simul_vec_q <= simul_vec_d;
  end

  // Output logic: decoded from the next state so every output is a flop.
  always_comb begin
    dut_clk_d = 1'b0;
    dut_d_d   = dut_d_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      PRE: begin
        busy_d  = 1'b1;
        dut_d_d = pre_edge_data(simul_vec_d[idx_d], pre_vec_d[idx_d], data_vec_d[idx_d]);
      end
      HIGH: begin
        busy_d    = 1'b1;
        dut_clk_d = 1'b1;
        dut_d_d   = data_vec_d[idx_d];
      end
      LOW: begin
        busy_d  = 1'b1;
        dut_d_d = data_vec_d[idx_d];
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_clk_q <= 1'b0;
      dut_d_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      dut_clk_q <= dut_clk_d;
      dut_d_q   <= dut_d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dut_clk = dut_clk_q;
  assign dut_d   = dut_d_q;
  assign busy    = busy_q;
  assign done    = done_q;

  dff_seq_checker #(
    .NUM_STEPS(NUM_STEPS),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .expect_in (step_expect),
    .sample    (sample),
    .last      (last),
    .idx       (idx_q),
    .dut_q     (dut_q),
    .fail_count(fail_count),
    .fail_mask (fail_mask),
    .pass      (pass)
  );

endmodule

// File: tb/tb_dff_edge_sequencer.sv
// Randomized self-checking bench with a step/phase reference model and a behavioural flop under test.
module tb_dff_edge_sequencer;
  import dff_seq_pkg::*;

  localparam int NS = 5;
  localparam int CW = $clog2(NS + 1);

  logic          clk, rst, start, dut_q;
  logic [NS-1:0] step_d, step_pre_d, step_simul, step_expect;
  logic          dut_clk, dut_d, busy, done, pass;
  logic [CW-1:0] fail_count;
  logic [NS-1:0] fail_mask;

  int n_checks = 0;
  int n_err    = 0;

  dff_edge_sequencer #(.NUM_STEPS(NS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step_d     (step_d),
    .step_pre_d (step_pre_d),
    .step_simul (step_simul),
    .step_expect(step_expect),
    .dut_q      (dut_q),
    .dut_clk    (dut_clk),
    .dut_d      (dut_d),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_mask  (fail_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Flop under test: q_mode 0 captures the d present with the rising clock, 1 captures the prior d.
  int   q_mode  = 0;
  bit   x_first = 0;
  logic prev_clk, prev_d;

  // Reference model: a run is 3*NS cycles; cycle c is step c/3, phase c%3 (PRE, HIGH, LOW).
  bit            m_valid = 0, m_active = 0, m_done = 0;
  int            m_cyc;
  logic [NS-1:0] lv_d, lv_pre, lv_sim, lv_exp, m_mask;
  logic          m_d, e_clk;

  initial begin : model_and_compare
    int step, ph;
    prev_clk = 1'b0;
    prev_d   = 1'b0;
    m_mask   = '0;
    m_d      = 1'b0;
    e_clk    = 1'b0;
    m_cyc    = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1; m_active = 0; m_done = 0; m_mask = '0; m_d = 1'b0;
      end else if (start && !m_active) begin
        lv_d = step_d; lv_pre = step_pre_d; lv_sim = step_simul; lv_exp = step_expect;
        m_active = 1; m_done = 0; m_mask = '0; m_cyc = 0;
      end else if (m_active) begin
        step = m_cyc / STEP_CYCLES;
        if ((m_cyc % STEP_CYCLES) == 2 && (dut_q !== lv_exp[step])) m_mask[step] = 1'b1;
        m_cyc++;
        if (m_cyc == STEP_CYCLES * NS) begin
          m_active = 0;
          m_done   = 1;
        end
      end
      e_clk = 1'b0;
      if (m_active) begin
        step  = m_cyc / STEP_CYCLES;
        ph    = m_cyc % STEP_CYCLES;
        e_clk = (ph == 1);
        m_d   = (ph == 0 && lv_sim[step]) ? lv_pre[step] : lv_d[step];
      end
      @(negedge clk);
      if (m_valid) begin
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("dut_clk", dut_clk, e_clk);
        check("dut_d", dut_d, m_d);
        check("fail_mask", fail_mask, m_mask);
        check("fail_count", fail_count, $countones(m_mask));
        check("pass", pass, m_done && (m_mask == '0));
      end
      if (dut_clk === 1'b1 && prev_clk === 1'b0) begin
        if (x_first) x_first = 0;
        else dut_q = (q_mode != 0) ? prev_d : dut_d;
      end
      prev_clk = dut_clk;
      prev_d   = dut_d;
    end
  end

  logic [1:0] tr [64];

  // disturb: 0 none, 1 extra start at cycle 4, 2 invert step_expect at cycle 5, 3 reset at cycle 7.
  task automatic do_run(input string nm, input int disturb, input logic [NS-1:0] exp_mask);
    int cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_at_start"}, busy, 1);
    check({nm, "_done_cleared"}, done, 0);
    check({nm, "_mask_cleared"}, fail_mask, 0);
    cnt   = 0;
    tr[0] = {dut_clk, dut_d};
    while (done !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (cnt < 64) tr[cnt] = {dut_clk, dut_d};
      if (disturb == 1) start = (cnt == 4);
      if (disturb == 2 && cnt == 5) step_expect = ~step_expect;
      if (disturb == 3 && cnt == 7) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({nm, "_abort_busy"}, busy, 0);
        check({nm, "_abort_done"}, done, 0);
        check({nm, "_abort_clk"}, dut_clk, 0);
        check({nm, "_abort_d"}, dut_d, 0);
        check({nm, "_abort_count"}, fail_count, 0);
        return;
      end
    end
    check({nm, "_latency"}, cnt, STEP_CYCLES * NS);
    check({nm, "_fail_mask"}, fail_mask, exp_mask);
    check({nm, "_fail_count"}, fail_count, $countones(exp_mask));
    check({nm, "_pass"}, pass, exp_mask == '0);
  endtask

  task automatic set_vec(input logic [NS-1:0] d, input logic [NS-1:0] pre,
                         input logic [NS-1:0] sim, input logic [NS-1:0] ex);
    step_d = d; step_pre_d = pre; step_simul = sim; step_expect = ex;
  endtask

  initial begin
    logic          x_val;
    logic [NS-1:0] cap, flip;
    rst   = 1'b1;
    start = 1'b0;
    dut_q = 1'b0;
    set_vec('0, '0, '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_clk", dut_clk, 0);
    check("reset_d", dut_d, 0);
    check("reset_count", fail_count, 0);
    check("reset_mask", fail_mask, 0);

    set_vec(5'b00110, 5'b01000, 5'b01100, 5'b00110);
    q_mode = 0;
    do_run("baseline", 0, 5'b00000);
    check("trace_s2_pre", tr[6], 2'b00);
    check("trace_s2_high", tr[7], 2'b11);
    check("trace_s3_pre", tr[9], 2'b01);
    check("trace_s3_high", tr[10], 2'b10);

    q_mode = 1;
    do_run("old_capture", 0, 5'b01100);

    q_mode = 0;
    do_run("start_busy", 1, 5'b00000);
    do_run("vec_change", 2, 5'b00000);
    set_vec(5'b00110, 5'b01000, 5'b01100, 5'b00110);
    do_run("reset_mid", 3, 5'b00000);
    do_run("after_reset", 0, 5'b00000);

    set_vec(5'b00111, 5'b01000, 5'b01100, 5'b00111);
    x_val   = 1'bx;
    dut_q   = x_val;
    x_first = 1;
    do_run("x_q", 0, {4'b0000, x_val !== 1'b1});
    do_run("restart_done", 0, 5'b00000);

    for (int r = 0; r < 24; r++) begin
      q_mode = int'($urandom_range(0, 1));
      set_vec(NS'($urandom), NS'($urandom), NS'($urandom), '0);
      cap  = (q_mode != 0) ? ((step_simul & step_pre_d) | (~step_simul & step_d)) : step_d;
      flip = NS'($urandom & $urandom & $urandom);
      step_expect = cap ^ flip;
      do_run("random", 0, flip);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
